rapcore_wb_spi: RTL and testbench
=================================

RAPCORE_WB_SPI -- requirements
Module: rapcore_wb_spi

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; bits [31:4] are decoded.
REQ-002 SHALL have parameter DIV_RESET, default 8'd3, reset value of CTRL.DIV.
REQ-003 SHALL have port wb_clk_i  input  1  the single clock.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have Wishbone slave ports wbs_stb_i, wbs_cyc_i, wbs_we_i (input, 1 each), wbs_sel_i (input, 4), wbs_dat_i and wbs_adr_i (input, 32 each), wbs_ack_o (output, 1) and wbs_dat_o (output, 32).
REQ-006 SHALL have port spi_sck_o  output  1  SPI clock to the rapcore SCK pad net.
REQ-007 SHALL have port spi_cs_o  output  1  active-low chip select.
REQ-008 SHALL have port spi_copi_o  output  1  serial data out.
REQ-009 SHALL have port spi_cipo_i  input  1  serial data in.
REQ-010 SHALL have port irq_o  output  1  transfer-done interrupt; present only per REQ-030.

Function
REQ-011 SHALL decode the register map at offset 0x0 CTRL (DIV[7:0], CS_HOLD[8]), 0x4 TXDATA, 0x8 STATUS (BUSY[0], DONE[1], OVERRUN[2]) and 0xC RXDATA, with offset bits adr[3:2].
REQ-012 SHALL assert wbs_ack_o for exactly one cycle, the cycle after a decoded stb&cyc, and deassert it the following cycle regardless of the master.
REQ-013 SHALL not ack undecoded addresses; decoded but unmapped reads return 0.
REQ-014 SHALL apply CTRL and TXDATA writes per wbs_sel_i byte lane.
REQ-015 SHALL start a transfer on any TXDATA write while BUSY=0; a TXDATA write while BUSY=1 is acked, discarded, and sets OVERRUN.
REQ-016 SHALL clear DONE and OVERRUN by writing 1 to the respective STATUS bit (W1C); set has priority over a simultaneous clear.
REQ-017 SHALL run SPI mode 0, MSB first, 32-bit frames: SCK idles low, COPI changes on SCK falling, CIPO is sampled on SCK rising.
REQ-018 SHALL have a half-period of DIV+1 clock cycles; DIV=0 gives SCK = clk/2.
REQ-019 SHALL implement the FSM IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> HOLD -> IDLE, each state lasting one half-period.
REQ-020 SHALL enter SETUP the cycle after the TXDATA ack, with BUSY=1, CS low and COPI=bit31.
REQ-021 SHALL perform 32 SHIFT_HI/SHIFT_LO pairs, then go from the 32nd SHIFT_LO to HOLD.
REQ-022 SHALL, on leaving HOLD, load RXDATA, set DONE, clear BUSY and raise CS unless CS_HOLD=1; total BUSY time is 66*(DIV+1) cycles.
REQ-023 SHALL, with CS_HOLD=1, keep CS low between back-to-back frames; clearing CS_HOLD while IDLE raises CS the next cycle.
REQ-024 SHALL latch DIV at transfer start; a CTRL write mid-transfer affects only the next transfer.
REQ-025 SHALL hold RXDATA at its previous value until the frame completes.

Reset
REQ-026 SHALL, with wb_rst_i high at a clock edge, set the FSM to IDLE, spi_sck_o=0, spi_cs_o=1, spi_copi_o=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, CTRL.DIV=DIV_RESET, CS_HOLD=0, and STATUS, TXDATA and RXDATA to 0.
REQ-027 SHALL abort a transfer in progress when reset occurs mid-transfer, with no partial RXDATA update.
REQ-028 SHALL hold all of the reset state from REQ-026 while wb_rst_i remains high.

Configuration
REQ-029 SHALL compile irq_o in only when macro RAPCORE_WB_SPI_IRQ_EN is defined.
REQ-030 SHALL, with RAPCORE_WB_SPI_IRQ_EN defined, drive irq_o = DONE (level, cleared via W1C); without it, omit the irq_o port and all its logic.

Structure
REQ-031 SHALL place the register offsets, STATUS bit indices, the FSM state encoding and the frame length 32 in the shared package rapcore_wb_spi_pkg.
REQ-032 SHALL implement the half-period counter and tick as the sub-module rapcore_spi_tick (inputs: enable, DIV; output: one-cycle tick).

Verification
REQ-033 SHALL cover: reset, then read CTRL -> 0x0000_0003; STATUS -> 0; spi_cs_o=1.
REQ-034 SHALL cover: DIV=0, write TXDATA 0xA5A5_F00D with CIPO looped to COPI -> BUSY for 66 cycles, 32 SCK rises, RXDATA=0xA5A5_F00D, DONE=1.
REQ-035 SHALL cover: DIV=3, write TXDATA 0x8000_0001 with CIPO tied to 1 -> SCK high/low 4 cycles each, BUSY for 264 cycles, RXDATA=0xFFFF_FFFF.
REQ-036 SHALL cover: a second TXDATA write 10 cycles into a transfer -> acked, OVERRUN=1, the first frame's COPI stream unchanged.
REQ-037 SHALL cover: CS_HOLD=1 with two back-to-back frames -> spi_cs_o stays 0 throughout; then clearing CS_HOLD -> spi_cs_o=1 next cycle.
REQ-038 SHALL cover: wb_rst_i pulsed at cycle 20 of a transfer -> next cycle sck=0, cs=1, BUSY=0, RXDATA=0.

Source files
------------

// File: rtl/rapcore_wb_spi_pkg.sv
// rapcore_wb_spi_pkg -- shared definitions for the Wishbone SPI master:
// register offsets, STATUS bit positions, FSM state encoding, frame length
// and a byte-lane merge helper.
package rapcore_wb_spi_pkg;

    // Bits per SPI frame
    localparam int FRAME_LEN = 32;

    // Register offsets, selected by wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RXDATA = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

    // CTRL field positions
    localparam int CTRL_CS_HOLD = 8;

    // Transfer sequencer states; each one lasts one SCK half-period
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_HOLD     = 3'd4
    } spi_state_t;

    // Replace only the bytes of old_val whose select bit is set
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rapcore_spi_tick.sv
// rapcore_spi_tick -- SCK half-period timer. While enabled it emits a
// one-cycle tick every div+1 clocks; the count restarts from zero whenever
// enable drops, so the first tick after enabling comes div+1 cycles later.
module rapcore_spi_tick (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] count;

    assign tick = enable && (count == div);

    // Half-period counter: wraps on tick, held at zero while disabled
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst || !enable) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/rapcore_wb_spi.sv
// rapcore_wb_spi -- Wishbone slave SPI master (mode 0, MSB first, 32-bit
// frames) for the rapcore SCK/CS/COPI/CIPO pads.
// Optional feature: define RAPCORE_WB_SPI_IRQ_EN to add the irq_o port,
// which mirrors STATUS.DONE.
module rapcore_wb_spi
    import rapcore_wb_spi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [7:0]  DIV_RESET = 8'd3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck_o,
    output logic        spi_cs_o,
    output logic        spi_copi_o,
    input  logic        spi_cipo_i
`ifdef RAPCORE_WB_SPI_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    // Register file
    logic [7:0]  ctrl_div;
    logic        ctrl_cs_hold;
    logic [31:0] txdata;
    logic [31:0] rxdata;
    logic        done;
    logic        overrun;

    // Transfer engine
    spi_state_t  state;
    logic [7:0]  div_lat;
    logic [31:0] tx_sh;
    logic [31:0] rx_sh;
    logic [4:0]  bit_cnt;
    logic        start_pending;
    logic        tick;

    // Bus decode
    logic        hit;
    logic        req;
    logic [1:0]  reg_sel;
    logic        busy;
    logic        frame_done;
    logic [31:0] rdata;
    logic        unused_adr;

    assign hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req        = wbs_stb_i && wbs_cyc_i && hit && !wbs_ack_o;
    assign reg_sel    = wbs_adr_i[3:2];
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_HOLD) && tick;
    assign unused_adr = ^wbs_adr_i[1:0];

`ifdef RAPCORE_WB_SPI_IRQ_EN
    assign irq_o = done;
`endif

    rapcore_spi_tick u_tick (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .enable (busy),
        .div    (div_lat),
        .tick   (tick)
    );

    // Register read mux for the addressed offset
    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch forms.
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata = {23'd0, ctrl_cs_hold, ctrl_div};
            REG_TXDATA: rdata = txdata;
            REG_STATUS: begin
                rdata[STAT_BUSY]    = busy;
                rdata[STAT_DONE]    = done;
                rdata[STAT_OVERRUN] = overrun;
            end
            REG_RXDATA: rdata = rxdata;
            default:    rdata = '0;
        endcase
    end

    // Wishbone slave: single-cycle ack, register writes, W1C status
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            ctrl_div      <= DIV_RESET;
            ctrl_cs_hold  <= 1'b0;
            txdata        <= '0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            start_pending <= 1'b0;
        end else begin
            // The ack guard in req makes the ack a one-cycle pulse even if
            // the master keeps stb asserted.
            wbs_ack_o     <= req;
            wbs_dat_o     <= (req && !wbs_we_i) ? rdata : '0;
            start_pending <= 1'b0;

            if (req && wbs_we_i) begin
                case (reg_sel)
                    REG_CTRL: begin
                        if (wbs_sel_i[0]) ctrl_div     <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) ctrl_cs_hold <= wbs_dat_i[CTRL_CS_HOLD];
                    end
                    REG_TXDATA: begin
                        // A frame in flight keeps its data; the write is
                        // dropped and flagged instead.
                        if (busy || start_pending) begin
                            overrun <= 1'b1;
                        end else begin
                            txdata        <= apply_sel(txdata, wbs_dat_i, wbs_sel_i);
                            start_pending <= 1'b1;
                        end
                    end
                    REG_STATUS: begin
                        if (wbs_sel_i[0] && wbs_dat_i[STAT_DONE])    done    <= 1'b0;
                        if (wbs_sel_i[0] && wbs_dat_i[STAT_OVERRUN]) overrun <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // Placed after the W1C so a same-cycle completion wins
            if (frame_done) done <= 1'b1;
        end
    end

    // Transfer FSM: SETUP, 32 SHIFT_HI/SHIFT_LO pairs, HOLD; drives the pads
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            spi_sck_o  <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_copi_o <= 1'b0;
            div_lat    <= DIV_RESET;
            tx_sh      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            rxdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    spi_sck_o <= 1'b0;
                    if (!ctrl_cs_hold) spi_cs_o <= 1'b1;
                    if (start_pending) begin
                        state      <= ST_SETUP;
                        spi_cs_o   <= 1'b0;
                        spi_copi_o <= txdata[FRAME_LEN-1];
                        tx_sh      <= {txdata[FRAME_LEN-2:0], 1'b0};
                        div_lat    <= ctrl_div;
                        bit_cnt    <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state     <= ST_SHIFT_HI;
                        spi_sck_o <= 1'b1;
                        rx_sh     <= {rx_sh[FRAME_LEN-2:0], spi_cipo_i};
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        state      <= ST_SHIFT_LO;
                        spi_sck_o  <= 1'b0;
                        spi_copi_o <= tx_sh[FRAME_LEN-1];
                        tx_sh      <= {tx_sh[FRAME_LEN-2:0], 1'b0};
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        if (bit_cnt == 5'(FRAME_LEN - 1)) begin
                            state <= ST_HOLD;
                        end else begin
                            state     <= ST_SHIFT_HI;
                            spi_sck_o <= 1'b1;
                            rx_sh     <= {rx_sh[FRAME_LEN-2:0], spi_cipo_i};
                            bit_cnt   <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state    <= ST_IDLE;
                        rxdata   <= rx_sh;
                        spi_cs_o <= ctrl_cs_hold ? 1'b0 : 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rapcore_wb_spi.sv
// tb_rapcore_wb_spi -- directed self-checking bench for rapcore_wb_spi.
module tb_rapcore_wb_spi;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_TXDATA = 32'h3000_0004;
    localparam logic [31:0] A_STATUS = 32'h3000_0008;
    localparam logic [31:0] A_RXDATA = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'h0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_adr = '0;
    logic        wb_ack;
    logic [31:0] wb_dat_r;
    logic        spi_sck;
    logic        spi_cs;
    logic        spi_copi;
    logic        spi_cipo;
    logic        loop_mode = 1'b1;
    logic        cipo_const = 1'b0;
`ifdef RAPCORE_WB_SPI_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign spi_cipo = loop_mode ? spi_copi : cipo_const;

    rapcore_wb_spi dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (wb_stb),
        .wbs_cyc_i  (wb_cyc),
        .wbs_we_i   (wb_we),
        .wbs_sel_i  (wb_sel),
        .wbs_dat_i  (wb_dat_w),
        .wbs_adr_i  (wb_adr),
        .wbs_ack_o  (wb_ack),
        .wbs_dat_o  (wb_dat_r),
        .spi_sck_o  (spi_sck),
        .spi_cs_o   (spi_cs),
        .spi_copi_o (spi_copi),
        .spi_cipo_i (spi_cipo)
`ifdef RAPCORE_WB_SPI_IRQ_EN
        ,
        .irq_o      (irq)
`endif
    );

    always #5 clk = ~clk;

    // Pad monitor: CS-low cycles, SCK rises, COPI bit at each rise and
    // histograms of SCK high / low (with CS low) run lengths.
    int          cs_low_cycles = 0;
    int          rises = 0;
    logic [31:0] mon_word = '0;
    int          hist_hi [16];
    int          hist_lo [16];
    int          hi_run = 0;
    int          lo_run = 0;
    logic        sck_prev = 1'b0;
    logic        cs_watch = 1'b0;
    int          cs_glitch = 0;
    int          cs_watch_cycles = 0;

    always @(negedge clk) begin
        if (spi_cs === 1'b0) cs_low_cycles++;
        if (cs_watch) begin
            cs_watch_cycles++;
            if (spi_cs !== 1'b0) cs_glitch++;
        end
        if (spi_sck === 1'b1) begin
            if (sck_prev !== 1'b1) begin
                rises++;
                mon_word = {mon_word[30:0], spi_copi};
                if (lo_run > 0) hist_lo[(lo_run > 15) ? 15 : lo_run]++;
                lo_run = 0;
            end
            hi_run++;
        end else begin
            if (sck_prev === 1'b1) begin
                hist_hi[(hi_run > 15) ? 15 : hi_run]++;
                hi_run = 0;
            end
            if (spi_cs === 1'b0) lo_run++;
            else lo_run = 0;
        end
        sck_prev = spi_sck;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // One bus access; returns in the ack cycle (or after 4 cycles without ack)
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
        @(negedge clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        acked = 1'b0;
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack === 1'b1) begin
                acked = 1'b1;
                rdata = wb_dat_r;
                break;
            end
        end
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        logic        acked;
        wb_access(1'b1, adr, dat, sel, rd, acked);
        n_checks++;
        if (acked !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ack adr=%h: no ack seen, ack required", adr);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
        logic acked;
        wb_access(1'b0, adr, '0, 4'hF, data, acked);
        n_checks++;
        if (acked !== 1'b1) begin
            n_fail++;
            $display("FAIL read_ack adr=%h: no ack seen, ack required", adr);
        end
    endtask

    // Waits (bounded) for CS to return high at the end of a frame
    task automatic wait_cs_high(input int budget, input string name);
        int n = 0;
        while (spi_cs !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (spi_cs !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: cs still %b after %0d cycles, required 1", name, spi_cs, budget);
        end
    endtask

    // Polls STATUS (bounded) until BUSY clears
    task automatic poll_idle(input string name);
        logic [31:0] st;
        int n = 0;
        st = 32'h1;
        while (st[0] !== 1'b0 && n < 60) begin
            wb_read(A_STATUS, st);
            n++;
        end
        n_checks++;
        if (st[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: BUSY still set after %0d polls, required 0", name, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        acked;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi_sck, spi_cs, spi_copi, wb_ack} !== 4'b0100 || wb_dat_r !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: sck/cs/copi/ack=%b dat=%h, required 0100 and 0",
                     {spi_sck, spi_cs, spi_copi, wb_ack}, wb_dat_r);
        end
        rst = 1'b0;
        wb_read(A_CTRL, rd);
        n_checks++;
        if (rd !== 32'h0000_0003) begin
            n_fail++; $display("FAIL reset_ctrl: got %h, required 00000003", rd);
        end
        wb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got %h, required 0", rd);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_rxdata: got %h, required 0", rd);
        end
        wb_read(A_TXDATA, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_txdata: got %h, required 0", rd);
        end
        n_checks++;
        if (spi_cs !== 1'b1) begin
            n_fail++; $display("FAIL reset_cs: got %b, required 1", spi_cs);
        end
        // Undecoded address must not be acked
        wb_access(1'b0, 32'h4000_0000, '0, 4'hF, rd, acked);
        n_checks++;
        if (acked !== 1'b0) begin
            n_fail++; $display("FAIL undecoded_ack: ack seen, required none");
        end
        // Ack lasts one cycle even with stb held
        @(negedge clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = A_CTRL; wb_sel = 4'hF;
        @(negedge clk);
        n_checks++;
        if (wb_ack !== 1'b1 || wb_dat_r !== 32'h3) begin
            n_fail++; $display("FAIL ack_first: ack=%b dat=%h, required 1 and 00000003", wb_ack, wb_dat_r);
        end
        @(negedge clk);
        n_checks++;
        if (wb_ack !== 1'b0) begin
            n_fail++; $display("FAIL ack_second: ack=%b, required 0", wb_ack);
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_div0();
        logic [31:0] rd;
        int c0, r0, h0;
        loop_mode = 1'b1;
        wb_write(A_CTRL, 32'h0, 4'b0001);
        c0 = cs_low_cycles; r0 = rises; h0 = hist_hi[1];
        wb_write(A_TXDATA, 32'hA5A5_F00D, 4'hF);
        @(negedge clk);
        n_checks++;
        if ({spi_cs, spi_sck, spi_copi} !== 3'b001) begin
            n_fail++; $display("FAIL setup_entry: cs/sck/copi=%b, required 001", {spi_cs, spi_sck, spi_copi});
        end
        wait_cs_high(200, "div0_end");
        n_checks++;
        if (cs_low_cycles - c0 !== 66) begin
            n_fail++; $display("FAIL div0_busy: got %0d cycles, required 66", cs_low_cycles - c0);
        end
        n_checks++;
        if (rises - r0 !== 32 || hist_hi[1] - h0 !== 32) begin
            n_fail++; $display("FAIL div0_sck: rises %0d hi1 %0d, required 32 32", rises - r0, hist_hi[1] - h0);
        end
        n_checks++;
        if (mon_word !== 32'hA5A5_F00D) begin
            n_fail++; $display("FAIL div0_copi: got %h, required a5a5f00d", mon_word);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'hA5A5_F00D) begin
            n_fail++; $display("FAIL div0_rxdata: got %h, required a5a5f00d", rd);
        end
        wb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL div0_status: got %h, required 00000002", rd);
        end
`ifdef RAPCORE_WB_SPI_IRQ_EN
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b, required 1", irq);
        end
`endif
        wb_write(A_STATUS, 32'h2, 4'b0001);
        wb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL done_w1c: got %h, required 0", rd);
        end
    endtask

    task automatic test_div3_ones();
        logic [31:0] rd;
        int c0, h0, l0;
        loop_mode = 1'b0;
        cipo_const = 1'b1;
        wb_write(A_CTRL, 32'h3, 4'b0001);
        c0 = cs_low_cycles; h0 = hist_hi[4]; l0 = hist_lo[4];
        wb_write(A_TXDATA, 32'h8000_0001, 4'hF);
        @(negedge clk);
        wait_cs_high(600, "div3_end");
        n_checks++;
        if (cs_low_cycles - c0 !== 264) begin
            n_fail++; $display("FAIL div3_busy: got %0d cycles, required 264", cs_low_cycles - c0);
        end
        n_checks++;
        if (hist_hi[4] - h0 !== 32 || hist_lo[4] - l0 !== 32) begin
            n_fail++; $display("FAIL div3_halfperiod: hi4 %0d lo4 %0d, required 32 32",
                               hist_hi[4] - h0, hist_lo[4] - l0);
        end
        n_checks++;
        if (mon_word !== 32'h8000_0001) begin
            n_fail++; $display("FAIL div3_copi: got %h, required 80000001", mon_word);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL div3_rxdata: got %h, required ffffffff", rd);
        end
        loop_mode = 1'b1;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        wb_write(A_CTRL, 32'hFFFF_FF07, 4'b0001);
        wb_read(A_CTRL, rd);
        n_checks++;
        if (rd !== 32'h0000_0007) begin
            n_fail++; $display("FAIL ctrl_lane: got %h, required 00000007", rd);
        end
        wb_write(A_CTRL, 32'h0, 4'b0001);
        wb_write(A_TXDATA, 32'h1234_5678, 4'b0100);
        @(negedge clk);
        wait_cs_high(200, "lanes_end");
        n_checks++;
        if (mon_word !== 32'h8034_0001) begin
            n_fail++; $display("FAIL tx_lane_copi: got %h, required 80340001", mon_word);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'h8034_0001) begin
            n_fail++; $display("FAIL tx_lane_rxdata: got %h, required 80340001", rd);
        end
        wb_write(A_STATUS, 32'h6, 4'b0001);
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        int c0;
        c0 = cs_low_cycles;
        wb_write(A_TXDATA, 32'h1357_9BDF, 4'hF);
        repeat (10) @(negedge clk);
        wb_write(A_TXDATA, 32'hFFFF_0000, 4'hF);
        wb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h5) begin
            n_fail++; $display("FAIL overrun_status_mid: got %h, required 00000005", rd);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'h8034_0001) begin
            n_fail++; $display("FAIL rxdata_hold: got %h, required 80340001", rd);
        end
        wait_cs_high(200, "overrun_end");
        n_checks++;
        if (mon_word !== 32'h1357_9BDF || cs_low_cycles - c0 !== 66) begin
            n_fail++; $display("FAIL overrun_stream: copi %h cycles %0d, required 13579bdf 66",
                               mon_word, cs_low_cycles - c0);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'h1357_9BDF) begin
            n_fail++; $display("FAIL overrun_rxdata: got %h, required 13579bdf", rd);
        end
        wb_read(A_TXDATA, rd);
        n_checks++;
        if (rd !== 32'h1357_9BDF) begin
            n_fail++; $display("FAIL overrun_discard: txdata %h, required 13579bdf", rd);
        end
        wb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h6) begin
            n_fail++; $display("FAIL overrun_status_end: got %h, required 00000006", rd);
        end
        wb_write(A_STATUS, 32'h6, 4'b0001);
        wb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL overrun_w1c: got %h, required 0", rd);
        end
    endtask

    task automatic test_div_latch();
        int c0;
        wb_write(A_CTRL, 32'h1, 4'b0001);
        c0 = cs_low_cycles;
        wb_write(A_TXDATA, 32'h0F0F_3C3C, 4'hF);
        repeat (5) @(negedge clk);
        wb_write(A_CTRL, 32'h0, 4'b0001);
        wait_cs_high(400, "latch_end1");
        n_checks++;
        if (cs_low_cycles - c0 !== 132) begin
            n_fail++; $display("FAIL div_latch_cur: got %0d cycles, required 132", cs_low_cycles - c0);
        end
        c0 = cs_low_cycles;
        wb_write(A_TXDATA, 32'h0000_0000, 4'hF);
        @(negedge clk);
        wait_cs_high(200, "latch_end2");
        n_checks++;
        if (cs_low_cycles - c0 !== 66) begin
            n_fail++; $display("FAIL div_latch_next: got %0d cycles, required 66", cs_low_cycles - c0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        wb_write(A_CTRL, 32'h100, 4'b0011);
        wb_write(A_TXDATA, 32'h0F0F_0F0F, 4'hF);
        @(negedge clk);
        cs_watch = 1'b1;
        poll_idle("b2b_frame1");
        wb_write(A_TXDATA, 32'hF0F0_F0F0, 4'hF);
        poll_idle("b2b_frame2");
        cs_watch = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cs_glitch !== 0 || cs_watch_cycles < 132) begin
            n_fail++; $display("FAIL cs_hold_low: %0d high cycles over %0d watched, required 0 over >=132",
                               cs_glitch, cs_watch_cycles);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'hF0F0_F0F0) begin
            n_fail++; $display("FAIL b2b_rxdata: got %h, required f0f0f0f0", rd);
        end
        wb_write(A_CTRL, 32'h0, 4'b0010);
        n_checks++;
        if (spi_cs !== 1'b0) begin
            n_fail++; $display("FAIL cs_release_early: got %b in ack cycle, required 0", spi_cs);
        end
        @(negedge clk);
        n_checks++;
        if (spi_cs !== 1'b1) begin
            n_fail++; $display("FAIL cs_release: got %b, required 1", spi_cs);
        end
        wb_write(A_STATUS, 32'h6, 4'b0001);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        wb_write(A_TXDATA, 32'hDEAD_BEEF, 4'hF);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({spi_sck, spi_cs, spi_copi} !== 3'b010) begin
            n_fail++; $display("FAIL reset_mid_pads: sck/cs/copi=%b, required 010", {spi_sck, spi_cs, spi_copi});
        end
        rst = 1'b0;
        wb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_status: got %h, required 0", rd);
        end
        wb_read(A_RXDATA, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_rxdata: got %h, required 0", rd);
        end
        wb_read(A_CTRL, rd);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++; $display("FAIL reset_mid_ctrl: got %h, required 00000003", rd);
        end
    endtask

    initial begin
        test_reset();
        test_loopback_div0();
        test_div3_ones();
        test_byte_lanes();
        test_overrun();
        test_div_latch();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
